mem_port_arbiter: RTL

Sequencing controller that shares one single-ported unified instruction/data memory between the pipeline's instruction-fetch stage and its MEM stage. It grants one requester at a time, with data access given priority over fetch. It drives a req/ack memory handshake, returns registered read data, and raises per-port stall signals that the hazard logic ORs into the PC-write and IF/ID-load holds. A taken-branch cancel discards an in-flight fetch, and a watchdog aborts accesses the memory never acknowledges.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_port_arbiter_ack_watchdog.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and defaults for the unified-memory port arbiter.
//   arbState_e : arbiter sequencing states (IDLE, BUSY, RESP)
//   owner_e    : which pipeline port owns the current memory access
//   DEFAULT_TIMEOUT : cycles mem_req may wait for mem_ack before abort
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arbState_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_port_arbiter_ack_watchdog.sv
// ack_watchdog
// Counts cycles of an outstanding memory request and flags when the
// memory has failed to acknowledge within TIMEOUT cycles.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-low
//   clear  : restart the count at zero (asserted when an access starts)
//   run    : an access is outstanding; advance the count
//   expire : high during the TIMEOUT-th waiting cycle, so the access is
//            abandoned at the edge where the count reaches TIMEOUT
module ack_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The count saturates at TIMEOUT so it can never wrap and fire a
  // second time if run were left asserted.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = run & ~clear & (count_q == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported instruction/data memory between the IF stage
// and the MEM stage. Data accesses win over fetches. The memory sees a
// registered req/ack handshake; results return through registered rdata
// and a one-cycle valid pulse. A taken branch (if_cancel) discards the
// result of a pending fetch without aborting the memory transaction,
// and a watchdog abandons accesses the memory never acknowledges.
// Ports:
//   clk, reset                      : clock, synchronous active-low reset
//   if_req/if_addr/if_cancel        : fetch request, PC, branch cancel
//   if_valid/if_rdata/if_stall      : fetch result pulse, data, stall
//   d_req/d_we/d_addr/d_wdata       : MEM-stage request
//   d_valid/d_rdata/d_stall         : MEM-stage completion, data, stall
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory request
//   mem_ack/mem_rdata               : memory acknowledge and read data
//   bus_err                         : sticky watchdog-abort flag
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int WORD_W  = 19,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              bus_err
);

  arbState_e         state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              drop_q, drop_d;
  logic              memReq_q, memReq_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [WORD_W-1:0] memWdata_q, memWdata_d;
  logic [WORD_W-1:0] ifRdata_q, ifRdata_d;
  logic [WORD_W-1:0] dRdata_q, dRdata_d;
  logic              busErr_q, busErr_d;

  logic              startData;
  logic              startFetch;
  logic              startAccess;
  logic              accessDone;
  logic              dropNow;
  logic              wdRun;
  logic              wdExpire;
  logic [WORD_W-1:0] captureWord;

  // Data has priority; a fetch that is being cancelled this very cycle
  // is never started, since its PC is already stale.
  assign startData   = (state_q == IDLE) & d_req;
  assign startFetch  = (state_q == IDLE) & ~d_req & if_req & ~if_cancel;
  assign startAccess = startData | startFetch;

  // An access ends on ack or on watchdog expiry; ack wins a tie.
  assign accessDone  = (state_q == BUSY) & (mem_ack | wdExpire);

  // A cancel arriving in the same cycle as the ack still discards the
  // fetch, otherwise the pipeline would receive a wrong-path instruction.
  assign dropNow     = (owner_q == OWN_FETCH) & (drop_q | if_cancel);

  // Writes and aborted accesses return zero rather than bus noise.
  assign captureWord = (mem_ack && !memWe_q) ? mem_rdata : '0;

  assign wdRun = (state_q == BUSY);

  ack_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (startAccess),
    .run   (wdRun),
    .expire(wdExpire)
  );

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_FETCH;
      drop_q     <= 1'b0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      ifRdata_q  <= '0;
      dRdata_q   <= '0;
      busErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      drop_q     <= drop_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      ifRdata_q  <= ifRdata_d;
      dRdata_q   <= dRdata_d;
      busErr_q   <= busErr_d;
    end
  end

  // Next-state logic. A dropped fetch skips RESP so no pulse is seen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (startAccess) state_d = BUSY;
      end
      BUSY: begin
        if (accessDone) state_d = dropNow ? IDLE : RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered memory/result outputs,
  // plus the valid pulses and stalls decoded from registered state.
  always_comb begin
    owner_d    = owner_q;
    drop_d     = drop_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    ifRdata_d  = ifRdata_q;
    dRdata_d   = dRdata_q;
    busErr_d   = busErr_q;

    if (startData) begin
      owner_d    = OWN_DATA;
      drop_d     = 1'b0;
      memReq_d   = 1'b1;
      memWe_d    = d_we;
      memAddr_d  = d_addr;
      memWdata_d = d_wdata;
    end else if (startFetch) begin
      owner_d    = OWN_FETCH;
      drop_d     = 1'b0;
      memReq_d   = 1'b1;
      memWe_d    = 1'b0;
      memAddr_d  = if_addr;
      memWdata_d = '0;
    end

    if (state_q == BUSY) begin
      if ((owner_q == OWN_FETCH) && if_cancel) drop_d = 1'b1;
      if (accessDone) begin
        memReq_d = 1'b0;
        if (owner_q == OWN_FETCH) begin
          ifRdata_d = captureWord;
        end else begin
          dRdata_d = captureWord;
        end
        if (!mem_ack) busErr_d = 1'b1;
      end
    end

    if_valid = (state_q == RESP) & (owner_q == OWN_FETCH) & ~if_cancel;
    d_valid  = (state_q == RESP) & (owner_q == OWN_DATA);
    if_stall = if_req & ~if_valid;
    d_stall  = d_req & ~d_valid;
  end

  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign if_rdata  = ifRdata_q;
  assign d_rdata   = dRdata_q;
  assign bus_err   = busErr_q;

endmodule
